// File: rtl/sram_like_mem.sv
// Behavioural sram-like bus memory slave: byte/half/word read-write with a
// fixed response latency, a bounded in-order response queue and a bench-driven
// stall input that only gates acceptance.
module sram_like_mem #(
  parameter int DEPTH_LOG2  = 16,
  parameter int LATENCY     = 1,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        wr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        stall_i,
  output logic        addr_ok_o,
  output logic        data_ok_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int CW   = 5;  // cycle counter / due stamp width
  localparam int NW   = 1 << DEPTH_LOG2;
  localparam int PW   = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNTW = 5;  // holds 0..16

  // Storage is intentionally not reset; benches preload/inspect it by name.
  logic [31:0] mem [NW];

  // Response FIFO: entries wait here until the cycle before they are due,
  // then move into the registered output stage.
  logic [31:0]   fifo_rdata_q [QUEUE_DEPTH];
  logic          fifo_err_q   [QUEUE_DEPTH];
  logic [CW-1:0] fifo_due_q   [QUEUE_DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic            data_ok_q, data_ok_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]            be;
  logic                  legal;
  logic                  accept, push, byp, head_hit;
  logic [31:0]           new_rdata;

  if (DEPTH_LOG2 < 30) begin : g_wrap
    // Upper address bits are ignored: the memory wraps.
    logic unused_addr;
    assign unused_addr = ^addr_i[31:DEPTH_LOG2+2];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idx = addr_i[DEPTH_LOG2+1:2];

  // Decode legality and lane enables from size and low address bits.
  always_comb begin
    legal = 1'b1;
    be    = 4'b0000;
    case (size_i)
      2'd0: be = 4'b0001 << addr_i[1:0];
      2'd1: begin
        legal = ~addr_i[0];
        be    = addr_i[1] ? 4'b1100 : 4'b0011;
      end
      2'd2: begin
        legal = (addr_i[1:0] == 2'b00);
        be    = 4'b1111;
      end
      default: legal = 1'b0;
    endcase
  end

  // The FIFO count excludes the entry sitting in the output stage, so
  // "outstanding minus this cycle's pop" reduces to the FIFO occupancy.
  assign addr_ok_o = req_i & ~stall_i & ~rst_i & (fifo_cnt_q < CNTW'(QUEUE_DEPTH));
  assign accept    = addr_ok_o;

  // With LATENCY=1 the response goes straight to the output stage.
  assign byp       = accept & (LATENCY == 1);
  assign push      = accept & (LATENCY != 1);
  assign head_hit  = (fifo_cnt_q != '0) & (fifo_due_q[rd_ptr_q] == cyc_d);
  assign new_rdata = (wr_i | ~legal) ? 32'h0 : mem[idx];

  // Next-state for pointers, counter and the registered response stage.
  always_comb begin
    cyc_d      = cyc_q + 1'b1;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = head_hit ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q + CNTW'(push) - CNTW'(head_hit);
    data_ok_d  = 1'b0;
    rdata_d    = 32'h0;
    err_d      = 1'b0;
    if (byp) begin
      data_ok_d = 1'b1;
      rdata_d   = new_rdata;
      err_d     = ~legal;
    end else if (head_hit) begin
      data_ok_d = 1'b1;
      rdata_d   = fifo_rdata_q[rd_ptr_q];
      err_d     = fifo_err_q[rd_ptr_q];
    end
  end

  // Control state; reset discards every pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      cyc_q      <= '0;
      data_ok_q  <= 1'b0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      cyc_q      <= cyc_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // FIFO payload: read data is snapshotted at accept time.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_rdata_q[wr_ptr_q] <= new_rdata;
      fifo_err_q[wr_ptr_q]   <= ~legal;
      fifo_due_q[wr_ptr_q]   <= cyc_q + CW'(LATENCY);
    end
  end

  // Lane-masked memory write for accepted legal writes.
  always_ff @(posedge clk_i) begin
    if (accept && wr_i && legal) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  // Outputs are forced quiet while reset is held.
  assign data_ok_o = data_ok_q & ~rst_i;
  assign rdata_o   = rst_i ? 32'h0 : rdata_q;
  assign err_o     = err_q & ~rst_i;

endmodule

// File: tb/tb_sram_like_mem.sv
// Bench for sram_like_mem: three instances (LATENCY/QUEUE_DEPTH 1/4, 3/2,
// 4/4) checked every cycle against a transaction-level reference model,
// plus directed scenarios with explicit expected values.
module tb_sram_like_mem;

  logic        clk, rst;
  logic        req [3];
  logic        wr [3];
  logic [1:0]  size [3];
  logic [31:0] addr [3];
  logic [31:0] wdata [3];
  logic        stall [3];
  logic        aok [3];
  logic        dok [3];
  logic [31:0] rdo [3];
  logic        err [3];

  sram_like_mem #(.DEPTH_LOG2(8), .LATENCY(1), .QUEUE_DEPTH(4)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .wr_i(wr[0]), .size_i(size[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .stall_i(stall[0]),
    .addr_ok_o(aok[0]), .data_ok_o(dok[0]), .rdata_o(rdo[0]), .err_o(err[0]));
  sram_like_mem #(.DEPTH_LOG2(8), .LATENCY(3), .QUEUE_DEPTH(2)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .wr_i(wr[1]), .size_i(size[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .stall_i(stall[1]),
    .addr_ok_o(aok[1]), .data_ok_o(dok[1]), .rdata_o(rdo[1]), .err_o(err[1]));
  sram_like_mem #(.DEPTH_LOG2(8), .LATENCY(4), .QUEUE_DEPTH(4)) u2 (
    .clk_i(clk), .rst_i(rst), .req_i(req[2]), .wr_i(wr[2]), .size_i(size[2]),
    .addr_i(addr[2]), .wdata_i(wdata[2]), .stall_i(stall[2]),
    .addr_ok_o(aok[2]), .data_ok_o(dok[2]), .rdata_o(rdo[2]), .err_o(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  resp_t       eq [3][$];     // expected responses in acceptance order
  logic [31:0] m [3][256];    // reference memory
  logic [31:0] iv [3][16];    // initial word values
  int          now;
  int          n_chk, n_err;
  logic        acc [3];
  logic        s_aok [3];
  logic        s_dok [3];
  logic        s_err [3];
  logic [31:0] s_rd [3];

  function automatic int lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 3 : 4;
  endfunction

  function automatic int qd(input int i);
    return (i == 1) ? 2 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one accepted request.
  task automatic apply(input int i);
    logic [31:0] a, word;
    logic        legal;
    int          nb, w, lane;
    a     = addr[i];
    legal = (size[i] == 2'd0) || (size[i] == 2'd1 && a[0] == 1'b0) ||
            (size[i] == 2'd2 && a[1:0] == 2'b00);
    w     = int'(a[9:2]);
    nb    = 1 << size[i];
    if (wr[i] && legal) begin
      word = m[i][w];
      for (int b = 0; b < nb; b++) begin
        lane = int'(a[1:0]) + b;
        word[8*lane +: 8] = wdata[i][8*lane +: 8];
      end
      m[i][w] = word;
    end
    eq[i].push_back('{rdata: (!wr[i] && legal) ? m[i][w] : 32'h0,
                      err: !legal, due: now + lat(i)});
  endtask

  // One clock cycle: sample at negedge, compare, advance the model.
  task automatic tick();
    logic ea, pop;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ea  = 1'b0;
        pop = 1'b0;
      end else begin
        pop = (eq[i].size() > 0) && (eq[i][0].due == now);
        ea  = req[i] && !stall[i] && (eq[i].size() - int'(pop) < qd(i));
      end
      chk($sformatf("u%0d.aok", i), 32'(aok[i]), 32'(ea));
      chk($sformatf("u%0d.dok", i), 32'(dok[i]), 32'(pop));
      chk($sformatf("u%0d.rdata", i), rdo[i], pop ? eq[i][0].rdata : 32'h0);
      chk($sformatf("u%0d.err", i), 32'(err[i]), pop ? 32'(eq[i][0].err) : 32'h0);
      s_aok[i] = aok[i];
      s_dok[i] = dok[i];
      s_rd[i]  = rdo[i];
      s_err[i] = err[i];
      acc[i]   = ea;
      if (rst) eq[i].delete();
      else begin
        if (pop) void'(eq[i].pop_front());
        if (ea) apply(i);
      end
    end
    now++;
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int i, input logic w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d);
    int n;
    req[i] = 1'b1; wr[i] = w; size[i] = sz; addr[i] = a; wdata[i] = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc[i] && n < 50);
    if (!acc[i]) chk($sformatf("u%0d.accept_timeout", i), 32'd0, 32'd1);
    req[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((eq[0].size() + eq[1].size() + eq[2].size()) > 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n), (n < 50) ? 32'(n) : 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; now = 0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; addr[i] = '0;
      wdata[i] = '0; stall[i] = 1'b0;
      for (int w = 0; w < 256; w++) m[i][w] = '0;
    end
    @(posedge clk); #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Preload the low 16 words of every instance over the bus.
    for (int i = 0; i < 3; i++)
      for (int w = 0; w < 16; w++) begin
        iv[i][w] = $urandom;
        xfer(i, 1'b1, 2'd2, 32'(w * 4), iv[i][w]);
      end
    drain();

    // Basic read at LATENCY=1.
    xfer(0, 1'b1, 2'd2, 32'h0, 32'h3c01ffff);
    tick();
    xfer(0, 1'b0, 2'd2, 32'h0, 32'h0);
    chk("basic_aok", 32'(s_aok[0]), 32'd1);
    tick();
    chk("basic_dok", 32'(s_dok[0]), 32'd1);
    chk("basic_rdata", s_rd[0], 32'h3c01ffff);
    chk("basic_err", 32'(s_err[0]), 32'd0);

    // Byte and halfword writes merge into the word.
    xfer(0, 1'b1, 2'd2, 32'h4, 32'h11223344);
    tick();
    chk("wr_dok", 32'(s_dok[0]), 32'd1);
    chk("wr_rdata", s_rd[0], 32'h0);
    xfer(0, 1'b1, 2'd0, 32'h5, 32'h0000AB00);
    tick();
    xfer(0, 1'b1, 2'd1, 32'h6, 32'hCDEF0000);
    tick();
    xfer(0, 1'b0, 2'd2, 32'h4, 32'h0);
    tick();
    chk("merge_rdata", s_rd[0], 32'hCDEFAB44);

    // Ordering: read-then-write sees old data, write-then-read sees new.
    xfer(0, 1'b1, 2'd2, 32'h10, 32'h01020304);
    tick();
    req[0] = 1'b1; wr[0] = 1'b0; size[0] = 2'd2; addr[0] = 32'h10;
    tick();
    wr[0] = 1'b1; wdata[0] = 32'hDEADBEEF;
    tick();
    chk("ord_old", s_rd[0], 32'h01020304);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 32'h14; wdata[0] = 32'hDEADBEEF;
    tick();
    wr[0] = 1'b0;
    tick();
    req[0] = 1'b0;
    tick();
    chk("ord_new", s_rd[0], 32'hDEADBEEF);

    // Illegal requests answer with err and leave memory alone.
    xfer(0, 1'b0, 2'd2, 32'h2, 32'h0);
    tick();
    chk("ill_word_err", 32'(s_err[0]), 32'd1);
    chk("ill_word_rdata", s_rd[0], 32'h0);
    xfer(0, 1'b1, 2'd1, 32'h1, 32'hFFFFFFFF);
    tick();
    chk("ill_half_err", 32'(s_err[0]), 32'd1);
    xfer(0, 1'b1, 2'd3, 32'h0, 32'hFFFFFFFF);
    tick();
    chk("ill_size3_err", 32'(s_err[0]), 32'd1);
    chk("ill_mem0", u0.mem[0], 32'h3c01ffff);

    // Back-pressure, LATENCY=3 QUEUE_DEPTH=2.
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h0;
    tick();                                        // T0
    chk("bp_t0_aok", 32'(s_aok[1]), 32'd1);
    tick();                                        // T1
    chk("bp_t1_aok", 32'(s_aok[1]), 32'd1);
    tick();                                        // T2 full
    chk("bp_t2_aok", 32'(s_aok[1]), 32'd0);
    tick();                                        // T3 pop + accept
    chk("bp_t3_aok", 32'(s_aok[1]), 32'd1);
    chk("bp_t3_dok", 32'(s_dok[1]), 32'd1);
    chk("bp_t3_rdata", s_rd[1], iv[1][0]);
    stall[1] = 1'b1;
    tick();                                        // T4
    chk("bp_t4_aok", 32'(s_aok[1]), 32'd0);
    chk("bp_t4_dok", 32'(s_dok[1]), 32'd1);
    stall[1] = 1'b0;
    tick();                                        // T5
    chk("bp_t5_aok", 32'(s_aok[1]), 32'd1);
    chk("bp_t5_dok", 32'(s_dok[1]), 32'd0);
    req[1] = 1'b0;
    tick();                                        // T6
    chk("bp_t6_dok", 32'(s_dok[1]), 32'd1);
    tick();
    chk("bp_t7_dok", 32'(s_dok[1]), 32'd0);
    tick();
    chk("bp_t8_dok", 32'(s_dok[1]), 32'd1);

    // Reset mid-flight, LATENCY=4.
    req[2] = 1'b1; wr[2] = 1'b0; size[2] = 2'd2; addr[2] = 32'h0;
    tick();
    tick();
    req[2] = 1'b0;
    rst = 1'b1;
    tick();
    chk("rst_dok", 32'(s_dok[2]), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rst_after_dok", 32'(s_dok[2]), 32'd0);
    end
    xfer(2, 1'b0, 2'd2, 32'h8, 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("rst_early_dok", 32'(s_dok[2]), 32'd0);
    end
    tick();
    chk("rst_new_dok", 32'(s_dok[2]), 32'd1);
    chk("rst_new_rdata", s_rd[2], iv[2][2]);

    // Randomized traffic on all instances, occasional reset.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        req[i]   = ($urandom_range(0, 9) < 7);
        wr[i]    = 1'($urandom_range(0, 1));
        size[i]  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        addr[i]  = 32'($urandom_range(0, 63));
        wdata[i] = $urandom;
        stall[i] = ($urandom_range(0, 4) == 0);
      end
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0;
      stall[i] = 1'b0;
    end
    drain();
    for (int w = 0; w < 16; w++)
      chk($sformatf("u0.mem[%0d]", w), u0.mem[w], m[0][w]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
